l2_i_controller: RTL and testbench
==================================

L2_I_CONTROLLER -- requirements
Module: l2_i_controller

Interface
REQ-001 SHALL have parameter TAG_W, default 21, width of the L1-to-L2 tag.
REQ-002 SHALL have parameter IDX_W, default 5, L2 set index width (32 sets, 2 ways).
REQ-003 SHALL provide these ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- read_L1_L2  in  1  L1-I miss request; held high by L1 until at least one cycle after ready_L2_L1.
- tag_L1_L2  in  TAG_W  requested tag.
- index_L1_L2  in  IDX_W  requested set.
- flush  in  1  invalidate all lines.
- ready_MEM_L2  in  1  memory line-fill complete (1-cycle pulse).
- ready_L2_L1  out  1  line available to L1 (1-cycle pulse).
- read_L2_MEM  out  1  memory fill request, level.
- tag_L2_MEM  out  TAG_W  fill tag.
- index_L2_MEM  out  IDX_W  fill set.
- refill_L2  out  1  data-array write strobe for the fill.
- way_L2  out  1  selected way for data-array read/write.
- busy  out  1  high whenever state != IDLE.
- L2_miss_o  out  1  1-cycle miss pulse for performance counters.

Function
REQ-004 SHALL hold TAG_ARR[64] x TAG_W, valid[64], LRU[32]; entry address {index, way}.
REQ-005 SHALL implement states IDLE, LOOKUP, FILL, RESPOND, RELEASE.
REQ-006 IDLE: read_L1_L2=1 -> latch tag/index into request registers, go LOOKUP; else stay.
REQ-007 LOOKUP (exactly 1 cycle): hit = valid && tag match in either way of latched set; hit -> RESPOND, miss -> FILL.
REQ-008 Way selection in LOOKUP, priority: way0 if hit/invalid, then way1 if hit/invalid, else LRU[index]; registered into way_L2, held until return to IDLE.
REQ-009 L2_miss_o SHALL pulse high for the single cycle after a LOOKUP miss (coincides with first FILL cycle).
REQ-010 FILL: read_L2_MEM=1, tag_L2_MEM/index_L2_MEM = latched request, stable throughout; ready_MEM_L2=1 -> write TAG_ARR, set valid at {index,way_L2}, go RESPOND.
REQ-011 refill_L2 SHALL be high for exactly the cycle following FILL's ready_MEM_L2 (first RESPOND cycle).
REQ-012 RESPOND (exactly 1 cycle): ready_L2_L1=1; LRU[index] <= ~way_L2; go RELEASE.
REQ-013 RELEASE: read_L1_L2=0 -> IDLE; else stay (prevents re-trigger on L1's lagging request).
REQ-014 Latency: hit -> ready_L2_L1 two cycles after read_L1_L2 first sampled in IDLE; miss -> ready_L2_L1 one cycle after ready_MEM_L2.
REQ-015 ready_MEM_L2 outside FILL SHALL be ignored (no tag/valid/refill change).
REQ-016 flush sampled in IDLE SHALL clear all valid and LRU bits next edge; flush in other states ignored.
REQ-017 flush and read_L1_L2 together in IDLE: clear applies and request accepted; LOOKUP SHALL see cleared valids (miss).
REQ-018 Request inputs changing after IDLE capture SHALL not affect the transaction.
REQ-019 busy, ready_L2_L1, read_L2_MEM SHALL be decoded from registered state only (glitch-free, no input-to-output path).

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, clear valid, LRU, way_L2, request registers; TAG_ARR contents need not clear.
REQ-021 All outputs SHALL be 0 during and the cycle after reset, including reset asserted mid-FILL (read_L2_MEM drops at that edge).
REQ-022 After reset release, first acceptable request edge SHALL be the next edge.

Verification
REQ-023 Cold miss: rst, read idx=3 tag=0x00ABC -> L2_miss_o pulse, read_L2_MEM with tag 0x00ABC/idx 3, way_L2=0; ready_MEM_L2 -> refill_L2, then ready_L2_L1 next cycle.
REQ-024 Hit: repeat same request after read drops -> no read_L2_MEM, ready_L2_L1 exactly 2 cycles after request, way_L2=0, LRU[3]=1.
REQ-025 Replacement: fill idx 3 with tags A, B (ways 0,1), access A, request C -> victim way_L2=1; subsequent B misses, A hits.
REQ-026 Held request: read_L1_L2 kept high 5 cycles after ready_L2_L1 -> exactly one ready pulse, state RELEASE until drop.
REQ-027 Flush+read same IDLE cycle on previously valid line -> miss path taken; stray ready_MEM_L2 in IDLE -> no state change.
REQ-028 rst during FILL -> read_L2_MEM low next cycle, busy=0, previously valid lines miss.

Source files
------------

// File: rtl/l2_i_controller_if.sv
// Signal bundle between the L2 instruction-cache controller, the L1-I above it
// and the memory below it. The controller sits on the slave side.
interface l2_i_controller_if #(
  parameter int TAG_W = 21,
  parameter int IDX_W = 5
);
  logic             read_L1_L2;
  logic [TAG_W-1:0] tag_L1_L2;
  logic [IDX_W-1:0] index_L1_L2;
  logic             flush;
  logic             ready_MEM_L2;
  logic             ready_L2_L1;
  logic             read_L2_MEM;
  logic [TAG_W-1:0] tag_L2_MEM;
  logic [IDX_W-1:0] index_L2_MEM;
  logic             refill_L2;
  logic             way_L2;
  logic             busy;
  logic             L2_miss_o;

  modport master (
    output read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
    input  ready_L2_L1, read_L2_MEM, tag_L2_MEM, index_L2_MEM,
           refill_L2, way_L2, busy, L2_miss_o
  );

  modport slave (
    input  read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
    output ready_L2_L1, read_L2_MEM, tag_L2_MEM, index_L2_MEM,
           refill_L2, way_L2, busy, L2_miss_o
  );
endinterface

// File: rtl/l2_i_controller.sv
// Two-way set-associative L2 instruction-cache tag controller.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | waiting for an L1 miss; flush accepted here only
//   S_LOOKUP  | one cycle: compare both ways of the latched set, pick a way
//   S_FILL    | line requested from memory, waiting for ready_MEM_L2
//   S_RESPOND | one cycle: ready_L2_L1 pulse, LRU updated
//   S_RELEASE | wait for L1 to drop its request so it is not re-served
module l2_i_controller #(
  parameter int TAG_W = 21,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  l2_i_controller_if.slave  bus
);

  localparam int N_SETS = 2 ** IDX_W;
  localparam int N_ENTR = 2 ** (IDX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_FILL    = 3'd2,
    S_RESPOND = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic             r_way;
  logic [N_ENTR-1:0] r_valid;
  logic [N_SETS-1:0] r_lru;
  logic [TAG_W-1:0] r_tag_arr [N_ENTR];
  logic             r_miss;
  logic             r_refill;

  logic [IDX_W:0]   w_ent0;
  logic [IDX_W:0]   w_ent1;
  logic             w_hit0;
  logic             w_hit1;
  logic             w_hit;
  logic             w_way_sel;
  logic             w_busy;
  logic             w_ready;
  logic             w_read_mem;

  assign w_ent0 = {r_idx, 1'b0};
  assign w_ent1 = {r_idx, 1'b1};
  assign w_hit0 = r_valid[w_ent0] && (r_tag_arr[w_ent0] == r_tag);
  assign w_hit1 = r_valid[w_ent1] && (r_tag_arr[w_ent1] == r_tag);
  assign w_hit  = w_hit0 || w_hit1;

  // Way choice: a hitting way wins, then an empty way, then the LRU victim.
  always_comb begin
    w_way_sel = r_lru[r_idx];
    if (w_hit0)               w_way_sel = 1'b0;
    else if (w_hit1)          w_way_sel = 1'b1;
    else if (!r_valid[w_ent0]) w_way_sel = 1'b0;
    else if (!r_valid[w_ent1]) w_way_sel = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.read_L1_L2) w_next = S_LOOKUP;
      S_LOOKUP:  w_next = w_hit ? S_RESPOND : S_FILL;
      S_FILL:    if (bus.ready_MEM_L2) w_next = S_RESPOND;
      S_RESPOND: w_next = S_RELEASE;
      S_RELEASE: if (!bus.read_L1_L2) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_ready    = (r_state == S_RESPOND);
    w_read_mem = (r_state == S_FILL);
  end

  // Request capture, way choice, valid/LRU bookkeeping and the pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag    <= '0;
      r_idx    <= '0;
      r_way    <= 1'b0;
      r_valid  <= '0;
      r_lru    <= '0;
      r_miss   <= 1'b0;
      r_refill <= 1'b0;
    end else begin
      r_miss   <= (r_state == S_LOOKUP) && !w_hit;
      r_refill <= (r_state == S_FILL) && bus.ready_MEM_L2;
      case (r_state)
        S_IDLE: begin
          if (bus.flush) begin
            r_valid <= '0;
            r_lru   <= '0;
          end
          if (bus.read_L1_L2) begin
            r_tag <= bus.tag_L1_L2;
            r_idx <= bus.index_L1_L2;
          end
        end
        S_LOOKUP:  r_way <= w_way_sel;
        S_FILL:    if (bus.ready_MEM_L2) r_valid[{r_idx, r_way}] <= 1'b1;
        S_RESPOND: r_lru[r_idx] <= ~r_way;
        default:   ;
      endcase
    end
  end

  // Tag storage; contents survive reset because the valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_FILL && bus.ready_MEM_L2)
      r_tag_arr[{r_idx, r_way}] <= r_tag;
  end

  assign bus.busy         = w_busy;
  assign bus.ready_L2_L1  = w_ready;
  assign bus.read_L2_MEM  = w_read_mem;
  assign bus.tag_L2_MEM   = r_tag;
  assign bus.index_L2_MEM = r_idx;
  assign bus.refill_L2    = r_refill;
  assign bus.way_L2       = r_way;
  assign bus.L2_miss_o    = r_miss;

endmodule

// File: tb/tb_l2_i_controller.sv
// Cycle-by-cycle directed bench for the L2 instruction-cache controller.
module tb_l2_i_controller;

  localparam int TAG_W = 21;
  localparam int IDX_W = 5;
  localparam logic [TAG_W-1:0] TA = 21'h00ABC;
  localparam logic [TAG_W-1:0] TB = 21'h00123;
  localparam logic [TAG_W-1:0] TC = 21'h00777;

  logic clk;
  logic rst;

  l2_i_controller_if #(.TAG_W(TAG_W), .IDX_W(IDX_W)) bus ();

  l2_i_controller #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             rd;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             fl;
    logic             rm;
    logic             e_rdy;
    logic             e_rmem;
    logic             e_busy;
    logic             e_miss;
    logic             e_refill;
    logic             e_way;
    logic [TAG_W-1:0] e_tag;
    logic [IDX_W-1:0] e_idx;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic rd, input logic [TAG_W-1:0] tag,
                     input logic [IDX_W-1:0] idx, input logic fl, input logic rm,
                     input logic rdy, input logic rmem, input logic busy,
                     input logic miss, input logic refill, input logic way,
                     input logic [TAG_W-1:0] etag, input logic [IDX_W-1:0] eidx);
    vec_t v;
    v.rst = r; v.rd = rd; v.tag = tag; v.idx = idx; v.fl = fl; v.rm = rm;
    v.e_rdy = rdy; v.e_rmem = rmem; v.e_busy = busy; v.e_miss = miss;
    v.e_refill = refill; v.e_way = way; v.e_tag = etag; v.e_idx = eidx;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [TAG_W-1:0] tag,
                       input logic [IDX_W-1:0] idx, input logic fl, input logic rm);
    rst              = r;
    bus.read_L1_L2   = rd;
    bus.tag_L1_L2    = tag;
    bus.index_L1_L2  = idx;
    bus.flush        = fl;
    bus.ready_MEM_L2 = rm;
  endtask

  initial begin
    int rdy_cnt;
    int first_rdy;
    int busy_low;
    int waited;

    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

    //   rst rd tag idx fl rm | rdy rmem busy miss refill way etag eidx
    add(1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r0 reset
    add(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r1 idle after reset
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r2 lookup cold A
    add(0, 1, TA, 3, 0, 0,   0, 1, 1, 1, 0, 0, TA, 3); // r3 fill, miss pulse
    add(0, 1, TA, 3, 0, 0,   0, 1, 1, 0, 0, 0, TA, 3); // r4 fill waits
    add(0, 1, TA, 3, 0, 1,   1, 0, 1, 0, 1, 0, 0,  0); // r5 respond+refill
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r6 release
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r7 idle
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r8 lookup A
    add(0, 1, TA, 3, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0); // r9 hit way0
    add(0, 0, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r10 release
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r11 idle
    add(0, 1, TB, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r12 lookup B
    add(0, 1, TC, 3, 0, 0,   0, 1, 1, 1, 0, 1, TB, 3); // r13 fill way1, input change ignored
    add(0, 1, TC, 3, 0, 1,   1, 0, 1, 0, 1, 1, 0,  0); // r14 respond
    add(0, 0, TC, 3, 0, 0,   0, 0, 1, 0, 0, 1, 0,  0); // r15 release
    add(0, 0, TC, 3, 0, 0,   0, 0, 0, 0, 0, 1, 0,  0); // r16 idle
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 1, 0,  0); // r17 lookup A
    add(0, 1, TA, 3, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0); // r18 hit way0, LRU->1
    add(0, 0, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r19
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r20
    add(0, 1, TC, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r21 lookup C
    add(0, 1, TC, 3, 0, 0,   0, 1, 1, 1, 0, 1, TC, 3); // r22 victim way1
    add(0, 1, TC, 3, 0, 1,   1, 0, 1, 0, 1, 1, 0,  0); // r23
    add(0, 0, TC, 3, 0, 0,   0, 0, 1, 0, 0, 1, 0,  0); // r24
    add(0, 0, TC, 3, 0, 0,   0, 0, 0, 0, 0, 1, 0,  0); // r25
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 1, 0,  0); // r26 lookup A
    add(0, 1, TA, 3, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0); // r27 A still hits
    add(0, 0, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r28
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r29
    add(0, 1, TB, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r30 lookup B
    add(0, 1, TB, 3, 0, 0,   0, 1, 1, 1, 0, 1, TB, 3); // r31 B evicted -> miss
    add(0, 1, TB, 3, 0, 1,   1, 0, 1, 0, 1, 1, 0,  0); // r32
    add(0, 0, TB, 3, 0, 0,   0, 0, 1, 0, 0, 1, 0,  0); // r33
    add(0, 0, TB, 3, 0, 0,   0, 0, 0, 0, 0, 1, 0,  0); // r34
    add(0, 0, TB, 3, 0, 1,   0, 0, 0, 0, 0, 1, 0,  0); // r35 stray mem ready
    add(0, 1, TA, 3, 1, 0,   0, 0, 1, 0, 0, 1, 0,  0); // r36 flush+read
    add(0, 1, TA, 3, 0, 0,   0, 1, 1, 1, 0, 0, TA, 3); // r37 miss after flush
    add(0, 1, TA, 3, 0, 1,   1, 0, 1, 0, 1, 0, 0,  0); // r38
    add(0, 0, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r39
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r40
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r41
    add(0, 1, TA, 3, 1, 0,   1, 0, 1, 0, 0, 0, 0,  0); // r42 flush in lookup ignored
    add(0, 0, TA, 3, 1, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r43 flush in respond ignored
    add(0, 0, TA, 3, 1, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r44 flush in release ignored
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r45
    add(0, 1, TA, 3, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0); // r46 still a hit
    add(0, 0, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r47
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r48
    add(0, 1, TA, 7, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r49 lookup idx 7
    add(0, 1, TA, 7, 0, 0,   0, 1, 1, 1, 0, 0, TA, 7); // r50 fill idx 7
    add(1, 1, TA, 7, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r51 reset mid-fill
    add(0, 1, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r52 accepted at once
    add(0, 1, TA, 3, 0, 0,   0, 1, 1, 1, 0, 0, TA, 3); // r53 valid cleared -> miss
    add(0, 1, TA, 3, 0, 1,   1, 0, 1, 0, 1, 0, 0,  0); // r54
    add(0, 0, TA, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0,  0); // r55
    add(0, 0, TA, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0); // r56

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rd, vecs[i].tag, vecs[i].idx, vecs[i].fl, vecs[i].rm);
      @(posedge clk);
      #1;
      chk("ready_L2_L1", i, 32'(bus.ready_L2_L1), 32'(vecs[i].e_rdy));
      chk("read_L2_MEM", i, 32'(bus.read_L2_MEM), 32'(vecs[i].e_rmem));
      chk("busy",        i, 32'(bus.busy),        32'(vecs[i].e_busy));
      chk("L2_miss_o",   i, 32'(bus.L2_miss_o),   32'(vecs[i].e_miss));
      chk("refill_L2",   i, 32'(bus.refill_L2),   32'(vecs[i].e_refill));
      chk("way_L2",      i, 32'(bus.way_L2),      32'(vecs[i].e_way));
      if (vecs[i].e_rmem) begin
        chk("tag_L2_MEM",   i, 32'(bus.tag_L2_MEM),   32'(vecs[i].e_tag));
        chk("index_L2_MEM", i, 32'(bus.index_L2_MEM), 32'(vecs[i].e_idx));
      end
    end

    // Request held high long after the response: one pulse, parked in release.
    rdy_cnt   = 0;
    first_rdy = -1;
    busy_low  = 0;
    drive(1'b0, 1'b1, TA, 5'd3, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_L2_L1) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = c;
      end
      if (!bus.busy) busy_low++;
    end
    chk("held_ready_pulses", 100, 32'(rdy_cnt), 32'd1);
    chk("held_hit_latency",  100, 32'(first_rdy), 32'd1);
    chk("held_busy_low",     100, 32'(busy_low), 32'd0);

    drive(1'b0, 1'b0, TA, 5'd3, 1'b0, 1'b0);
    waited = 0;
    while (bus.busy && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("release_to_idle_busy",   101, 32'(bus.busy), 32'd0);
    chk("release_to_idle_cycles", 101, 32'(waited),   32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
